// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcode bytes (with 0xCB prefix), walks micro-ops through the ROM,
// stalls on bus accesses, and handles HALT, interrupt entry and a runaway-sequence trap.
//   state    | meaning
//   FETCH    | requesting opcode or prefix byte
//   FETCH_CB | prefix seen, requesting second byte
//   EXEC     | micro-op at uop_addr is live
//   HALT     | waiting for any pending interrupt
//   TRAP     | step limit exceeded, frozen until reset
module microcode_sequencer #(
    parameter logic [7:0]  CB_PREFIX = 8'hCB,
    parameter logic [7:0]  HALT_OP   = 8'h76,
    parameter logic [8:0]  IRQ_UADDR = 9'h1B0,
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_fetch_req,
    input  logic       i_fetch_valid,
    input  logic [7:0] i_fetch_byte,
    output logic       o_pc_inc,
    output logic [8:0] o_uop_addr,
    output logic       o_uop_valid,
    input  logic       i_uop_last,
    input  logic [8:0] i_uop_next,
    input  logic       i_uop_mem,
    input  logic       i_mem_ready,
    input  logic       i_irq_pending,
    input  logic       i_ime,
    output logic       o_irq_ack,
    output logic       o_halted,
    output logic       o_fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_CB,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [4:0] LP_LAST_STEP = 5'(MAX_STEPS - 1);

    state_t     r_state;
    logic [8:0] r_uop_addr;
    logic [4:0] r_cnt;
    logic       r_cb;
    logic       r_halt_op;
    logic       r_fetch_req;
    logic       r_pc_inc;
    logic       r_uop_valid;
    logic       r_irq_ack;
    logic       r_halted;
    logic       r_fault;

    state_t     w_state_nxt;
    logic [8:0] w_addr_nxt;
    logic [4:0] w_cnt_nxt;
    logic       w_cb_nxt;
    logic       w_halt_op_nxt;
    logic       w_pc_inc_nxt;
    logic       w_irq_ack_nxt;
    logic       w_fault_nxt;
    logic       w_fetch_ok;
    logic       w_retire;
    logic       w_take_irq;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_uop_addr;
        w_cnt_nxt     = r_cnt;
        w_cb_nxt      = r_cb;
        w_halt_op_nxt = r_halt_op;
        w_pc_inc_nxt  = 1'b0;
        w_irq_ack_nxt = 1'b0;
        w_fault_nxt   = r_fault;
        // a byte only counts once the request is actually visible on the bus
        w_fetch_ok    = i_fetch_valid && r_fetch_req;
        w_retire      = !i_uop_mem || i_mem_ready;
        w_take_irq    = i_ime && i_irq_pending;

        case (r_state)
            S_FETCH: begin
                if (w_fetch_ok) begin
                    w_pc_inc_nxt = 1'b1;
                    if (i_fetch_byte == CB_PREFIX) begin
                        w_cb_nxt      = 1'b1;
                        w_halt_op_nxt = 1'b0;
                        w_state_nxt   = S_FETCH_CB;
                    end else begin
                        w_cb_nxt      = 1'b0;
                        w_halt_op_nxt = (i_fetch_byte == HALT_OP);
                        w_addr_nxt    = {1'b0, i_fetch_byte};
                        w_state_nxt   = S_EXEC;
                    end
                end
            end
            S_FETCH_CB: begin
                if (w_fetch_ok) begin
                    w_pc_inc_nxt = 1'b1;
                    w_addr_nxt   = {1'b1, i_fetch_byte};
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_uop_valid && w_retire) begin
                    if (!i_uop_last) begin
                        if (r_cnt == LP_LAST_STEP) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = S_TRAP;
                        end else begin
                            w_addr_nxt = i_uop_next;
                            w_cnt_nxt  = r_cnt + 5'd1;
                        end
                    end else begin
                        w_cnt_nxt = 5'd0;
                        // interrupts are only sampled at an instruction boundary
                        if (w_take_irq) begin
                            w_addr_nxt    = IRQ_UADDR;
                            w_irq_ack_nxt = 1'b1;
                            w_halt_op_nxt = 1'b0;
                            w_cb_nxt      = 1'b0;
                        end else if (r_halt_op) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
            end
            S_HALT: begin
                if (i_irq_pending) begin
                    if (i_ime) begin
                        w_addr_nxt    = IRQ_UADDR;
                        w_irq_ack_nxt = 1'b1;
                        w_halt_op_nxt = 1'b0;
                        w_cb_nxt      = 1'b0;
                        w_state_nxt   = S_EXEC;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_uop_addr  <= 9'd0;
            r_cnt       <= 5'd0;
            r_cb        <= 1'b0;
            r_halt_op   <= 1'b0;
            r_fetch_req <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_uop_valid <= 1'b0;
            r_irq_ack   <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_uop_addr  <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cb        <= w_cb_nxt;
            r_halt_op   <= w_halt_op_nxt;
            r_fetch_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_FETCH_CB);
            r_pc_inc    <= w_pc_inc_nxt;
            r_uop_valid <= (w_state_nxt == S_EXEC);
            r_irq_ack   <= w_irq_ack_nxt;
            r_halted    <= (w_state_nxt == S_HALT);
            r_fault     <= w_fault_nxt;
        end
    end

    assign o_fetch_req = r_fetch_req;
    assign o_pc_inc    = r_pc_inc;
    assign o_uop_addr  = r_uop_addr;
    assign o_uop_valid = r_uop_valid;
    assign o_irq_ack   = r_irq_ack;
    assign o_halted    = r_halted;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus a randomized instruction stream whose
// expected micro-address trace comes from walking a bench-side microcode ROM.
module tb_microcode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req;
    logic       fetch_valid;
    logic [7:0] fetch_byte;
    logic       pc_inc;
    logic [8:0] uop_addr;
    logic       uop_valid;
    logic       uop_last;
    logic [8:0] uop_next;
    logic       uop_mem;
    logic       mem_ready;
    logic       irq_pending;
    logic       ime;
    logic       irq_ack;
    logic       halted;
    logic       fault;

    logic       rom_last [512];
    logic [8:0] rom_next [512];
    logic       rom_mem  [512];
    bit         used     [512];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign uop_last = rom_last[uop_addr];
    assign uop_next = rom_next[uop_addr];
    assign uop_mem  = rom_mem[uop_addr];

    microcode_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_fetch_req   (fetch_req),
        .i_fetch_valid (fetch_valid),
        .i_fetch_byte  (fetch_byte),
        .o_pc_inc      (pc_inc),
        .o_uop_addr    (uop_addr),
        .o_uop_valid   (uop_valid),
        .i_uop_last    (uop_last),
        .i_uop_next    (uop_next),
        .i_uop_mem     (uop_mem),
        .i_mem_ready   (mem_ready),
        .i_irq_pending (irq_pending),
        .i_ime         (ime),
        .o_irq_ack     (irq_ack),
        .o_halted      (halted),
        .o_fault       (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, fetch_req, pc_inc, uop_addr, uop_valid, irq_ack, halted, fault};
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 512; i++) begin
            rom_last[i] = 1'b1;
            rom_next[i] = 9'd0;
            rom_mem[i]  = 1'b0;
            used[i]     = 1'b0;
        end
    endtask

    task automatic rom_set(input int a, input logic l, input logic [8:0] n, input logic m);
        rom_last[a] = l;
        rom_next[a] = n;
        rom_mem[a]  = m;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_byte  = 8'h00;
        mem_ready   = 1'b1;
        irq_pending = 1'b0;
        ime         = 1'b0;
        tick();
        tick();
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [7:0] b);
        for (int n = 0; n < 20 && !fetch_req; n++) tick();
        check("fetch_req_wait", {31'd0, fetch_req}, 32'd1);
        fetch_valid = 1'b1;
        fetch_byte  = b;
        tick();
        fetch_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         uv;
        int         n1c0;
        int         acks;
        int         nhalt;
        int         pcs;
        int         nb;
        bit         done;
        bit         cbk;
        logic [7:0] b;
        logic [8:0] st;
        logic [8:0] a;
        int         len;
        int         k;
        logic       k_cb    [8];
        logic [7:0] k_byte  [8];
        logic [8:0] k_start [8];
        logic [7:0] q_bytes [$];
        logic [8:0] exp_tr  [$];
        logic [8:0] obs_tr  [$];

        rom_clear();
        do_reset();
        check("fetch_req_after_reset", {31'd0, fetch_req}, 32'd1);

        // T1: single micro-op instruction
        rom_set(9'h000, 1'b1, 9'h000, 1'b0);
        fetch(8'h00);
        check("t1_addr", {23'd0, uop_addr}, 32'h000);
        check("t1_valid", {31'd0, uop_valid}, 32'd1);
        check("t1_pc_inc", {31'd0, pc_inc}, 32'd1);
        check("t1_fetch_req_low", {31'd0, fetch_req}, 32'd0);
        tick();
        check("t1_back_fetch", {30'd0, fetch_req, uop_valid}, 32'b10);
        check("t1_pc_inc_once", {31'd0, pc_inc}, 32'd0);

        // T2: prefixed opcode
        rom_set(9'h137, 1'b1, 9'h000, 1'b0);
        fetch(8'hCB);
        check("t2_pc_inc_prefix", {31'd0, pc_inc}, 32'd1);
        check("t2_no_valid_cb", {31'd0, uop_valid}, 32'd0);
        tick();
        check("t2_idle_cb", {29'd0, fetch_req, pc_inc, uop_valid}, 32'b100);
        fetch(8'h37);
        check("t2_pc_inc_second", {31'd0, pc_inc}, 32'd1);
        check("t2_addr", {22'd0, uop_valid, uop_addr}, {22'd0, 1'b1, 9'h137});
        tick();
        check("t2_back_fetch", {30'd0, fetch_req, uop_valid}, 32'b10);

        // T3: memory stall holds the micro-op
        rom_clear();
        rom_set(9'h03E, 1'b0, 9'h1C0, 1'b0);
        rom_set(9'h1C0, 1'b0, 9'h1C1, 1'b1);
        rom_set(9'h1C1, 1'b1, 9'h000, 1'b0);
        mem_ready = 1'b0;
        fetch(8'h3E);
        uv = 0;
        n1c0 = 0;
        a = 9'd0;
        for (int c = 0; c < 20 && uop_valid; c++) begin
            uv++;
            a = uop_addr;
            if (uop_addr == 9'h1C0) n1c0++;
            mem_ready = (n1c0 == 5);
            tick();
        end
        check("t3_hold_cycles", n1c0, 32'd5);
        check("t3_valid_cycles", uv, 32'd7);
        check("t3_last_addr", {23'd0, a}, 32'h1C1);
        check("t3_back_fetch", {31'd0, fetch_req}, 32'd1);
        mem_ready = 1'b1;

        // T4: interrupt only at the instruction boundary
        rom_set(9'h010, 1'b0, 9'h011, 1'b0);
        rom_set(9'h011, 1'b0, 9'h012, 1'b0);
        rom_set(9'h012, 1'b1, 9'h000, 1'b0);
        rom_set(9'h1B0, 1'b0, 9'h1B1, 1'b0);
        rom_set(9'h1B1, 1'b1, 9'h000, 1'b0);
        fetch(8'h10);
        irq_pending = 1'b1;
        ime = 1'b1;
        check("t4_first", {22'd0, irq_ack, uop_addr}, {22'd0, 1'b0, 9'h010});
        tick();
        check("t4_mid1", {22'd0, irq_ack, uop_addr}, {22'd0, 1'b0, 9'h011});
        tick();
        check("t4_mid2", {22'd0, irq_ack, uop_addr}, {22'd0, 1'b0, 9'h012});
        tick();
        check("t4_irq_entry", {21'd0, irq_ack, uop_valid, uop_addr}, {21'd0, 2'b11, 9'h1B0});
        irq_pending = 1'b0;
        tick();
        check("t4_ack_one_cycle", {22'd0, irq_ack, uop_addr}, {22'd0, 1'b0, 9'h1B1});
        tick();
        check("t4_irq_done", {30'd0, fetch_req, uop_valid}, 32'b10);
        irq_pending = 1'b1;
        ime = 1'b0;
        fetch(8'h10);
        uv = 0;
        acks = 0;
        for (int c = 0; c < 20 && uop_valid; c++) begin
            uv++;
            tick();
            if (irq_ack) acks++;
        end
        check("t4_ime0_len", uv, 32'd3);
        check("t4_ime0_no_ack", acks, 32'd0);
        check("t4_ime0_fetch", {31'd0, fetch_req}, 32'd1);
        irq_pending = 1'b0;

        // T5: HALT, then wake with and without service
        rom_set(9'h076, 1'b1, 9'h000, 1'b0);
        fetch(8'h76);
        check("t5_halt_uop", {23'd0, uop_addr}, 32'h076);
        tick();
        check("t5_halted", {29'd0, halted, uop_valid, fetch_req}, 32'b100);
        nhalt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (halted) nhalt++;
        end
        check("t5_halt_held", nhalt, 32'd10);
        irq_pending = 1'b1;
        ime = 1'b0;
        tick();
        check("t5_wake_no_ime", {29'd0, halted, fetch_req, irq_ack}, 32'b010);
        irq_pending = 1'b0;
        fetch(8'h76);
        tick();
        check("t5_halted_again", {31'd0, halted}, 32'd1);
        irq_pending = 1'b1;
        ime = 1'b1;
        tick();
        check("t5_wake_irq", {20'd0, halted, irq_ack, uop_valid, uop_addr}, {20'd0, 3'b011, 9'h1B0});
        irq_pending = 1'b0;
        tick();
        tick();
        check("t5_irq_seq_done", {30'd0, fetch_req, irq_ack}, 32'b10);
        ime = 1'b0;

        // T6: runaway sequence traps; reset clears asynchronously
        rom_set(9'h020, 1'b0, 9'h020, 1'b0);
        fetch(8'h20);
        uv = 0;
        for (int c = 0; c < 40 && !fault; c++) begin
            if (uop_valid) uv++;
            tick();
        end
        check("t6_steps_before_fault", uv, 32'd16);
        check("t6_trap", {29'd0, fault, uop_valid, fetch_req}, 32'b100);
        fetch_valid = 1'b1;
        fetch_byte = 8'h00;
        tick();
        tick();
        fetch_valid = 1'b0;
        check("t6_trap_held", {28'd0, fault, uop_valid, fetch_req, pc_inc}, 32'b1000);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_reset_trap", all_outs(), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rom_set(9'h040, 1'b0, 9'h041, 1'b1);
        mem_ready = 1'b0;
        fetch(8'h40);
        tick();
        check("t6_stalling", {22'd0, uop_valid, uop_addr}, {22'd0, 1'b1, 9'h040});
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_reset_stall", all_outs(), 32'd0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();

        // randomized instruction stream against a walked microcode ROM
        rom_clear();
        for (int kk = 0; kk < 8; kk++) begin
            do begin
                cbk = ($urandom_range(0, 2) == 0);
                b = cbk ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255));
                st = {cbk, b};
            end while (used[st] || (!cbk && (b == 8'h76 || b == 8'hCB)));
            used[st] = 1'b1;
            k_cb[kk] = cbk;
            k_byte[kk] = b;
            k_start[kk] = st;
            len = $urandom_range(1, 7);
            a = st;
            for (int j = 1; j <= len; j++) begin
                logic [8:0] nxt;
                nxt = 9'(9'h1C0 + kk * 8 + j);
                rom_set(a, (j == len), nxt, 1'($urandom_range(0, 1)));
                a = nxt;
            end
        end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            if (k_cb[k]) q_bytes.push_back(8'hCB);
            q_bytes.push_back(k_byte[k]);
            a = k_start[k];
            for (int s = 0; s < 16; s++) begin
                exp_tr.push_back(a);
                if (rom_last[a]) break;
                a = rom_next[a];
            end
        end
        nb = q_bytes.size();
        pcs = 0;
        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (q_bytes.size() == 0 && fetch_req) begin
                done = 1'b1;
            end else begin
                fetch_valid = fetch_req && (q_bytes.size() > 0) && ($urandom_range(0, 1) == 1);
                if (fetch_valid) fetch_byte = q_bytes.pop_front();
                mem_ready = ($urandom_range(0, 1) == 1);
                if (uop_valid && (!uop_mem || mem_ready)) obs_tr.push_back(uop_addr);
                tick();
                if (pc_inc) pcs++;
            end
        end
        fetch_valid = 1'b0;
        check("rand_done", {31'd0, done}, 32'd1);
        check("rand_pc_inc_count", pcs, nb);
        check("rand_trace_len", obs_tr.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < obs_tr.size(); i++)
            check("rand_trace_addr", {23'd0, obs_tr[i]}, {23'd0, exp_tr[i]});
        check("rand_no_fault", {31'd0, fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
